// File: rtl/csa_resolver_pkg.sv
// ---------------------------------------------------------------------------
// csa_resolver_pkg
// Shared types and elaboration-time helpers for the carry-save resolver.
//   state_e      : controller states (IDLE, BUSY, DONE)
//   calc_nbeats  : beats needed to resolve a WIDTH+1 bit operand CHUNK bits
//                  at a time, ceil((WIDTH+1)/CHUNK)
//   cnt_width    : beat counter width, clog2(NBEATS) but never below 1
// ---------------------------------------------------------------------------
package csa_resolver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_nbeats(input int width, input int chunk);
    return (width + 1 + chunk - 1) / chunk;
  endfunction

  function automatic int cnt_width(input int nbeats);
    return (nbeats <= 1) ? 1 : $clog2(nbeats);
  endfunction

endpackage

// File: rtl/csa_resolver_slice.sv
// ---------------------------------------------------------------------------
// csa_resolver_slice
// Combinational CHUNK-bit adder used once per beat by csa_resolver.
//   a, b  : CHUNK-bit operand slices
//   cin   : carry from the previous beat
//   s     : CHUNK-bit slice sum
//   cout  : carry into the next beat
// ---------------------------------------------------------------------------
module csa_resolver_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  // One bit of headroom captures the slice carry-out.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/csa_resolver.sv
// ---------------------------------------------------------------------------
// csa_resolver
// Turns a carry-save pair (sum vector + carry vector) into an exact binary
// value by iterating a CHUNK-bit adder slice over NBEATS beats.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   in_valid    carry-save pair presented
//   in_ready    high only in IDLE
//   in_sum      sum vector, bit i weighs 2^i
//   in_cout     carry vector, bit i weighs 2^(i+1)
//   out_valid   high only in DONE
//   out_ready   downstream accepts the result
//   out_result  in_sum + 2*in_cout, WIDTH+2 bits, exact
//   out_ovf     present only when CSA_RESOLVER_OVF_EN is defined: high when
//               the result does not fit in WIDTH bits
//
// Optional feature macro: CSA_RESOLVER_OVF_EN
// ---------------------------------------------------------------------------
module csa_resolver
  import csa_resolver_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_result
`ifdef CSA_RESOLVER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NBEATS = calc_nbeats(WIDTH, CHUNK);
  localparam int PW     = NBEATS * CHUNK;   // padded operand width
  localparam int CW     = cnt_width(NBEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;
  logic [PW-1:0]   b_q, b_d;
  logic [PW-1:0]   res_q, res_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [PW-1:0]    a_pad, b_pad;
  logic [PW-1:0]    res_shift;
  logic [CHUNK-1:0] slice_s;
  logic             slice_cout;

  // A = {0, in_sum}, B = {in_cout, 0}, both zero-extended to the padded width.
  assign a_pad = PW'({1'b0, in_sum});
  assign b_pad = PW'({in_cout, 1'b0});

  csa_resolver_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Each beat's sum enters at the top, so after NBEATS beats the first
  // (least significant) slice has arrived at bit 0.
  generate
    if (NBEATS == 1) begin : g_res_single
      assign res_shift = slice_s;
    end else begin : g_res_multi
      assign res_shift = {slice_s, res_q[PW-1:CHUNK]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_pad;
          b_d     = b_pad;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = res_shift;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BEAT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  // The final carry sits above the result register; the padded result is
  // always at least WIDTH+1 bits, so truncation never drops a set bit.
  assign out_result = (WIDTH + 2)'({carry_q, res_q});

`ifdef CSA_RESOLVER_OVF_EN
  // Taken straight from the result registers, which only change in BUSY,
  // so it is stable and aligned with out_valid.
  assign out_ovf = out_result[WIDTH+1] | out_result[WIDTH];
`endif

endmodule

// File: tb/tb_csa_resolver.sv
// ---------------------------------------------------------------------------
// tb_csa_resolver
// Three resolvers (CHUNK = 8, 33, 5; WIDTH = 32) share one stimulus stream.
// Each has its own handshake model: a pending flag, the expected exact sum
// and the cycle it was accepted; out_valid is expected NBEATS cycles later.
// Directed transactions pin literal results, latency and stall behaviour.
// ---------------------------------------------------------------------------
module tb_csa_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_sum;
  logic [31:0] in_cout;
  logic        out_ready;

  logic        rdy [3];
  logic        vld [3];
  logic [33:0] res [3];
  logic        ovf [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done0  = 0;

  // Model state per instance
  int          nb [3] = '{5, 1, 7};
  logic        pend [3];
  logic [33:0] expv [3];
  int          acc [3];

  always #5 clk = ~clk;

  csa_resolver #(.WIDTH(32), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_sum(in_sum), .in_cout(in_cout), .out_valid(vld[0]),
    .out_ready(out_ready), .out_result(res[0])
`ifdef CSA_RESOLVER_OVF_EN
    , .out_ovf(ovf[0])
`endif
  );

  csa_resolver #(.WIDTH(32), .CHUNK(33)) u_c33 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_sum(in_sum), .in_cout(in_cout), .out_valid(vld[1]),
    .out_ready(out_ready), .out_result(res[1])
`ifdef CSA_RESOLVER_OVF_EN
    , .out_ovf(ovf[1])
`endif
  );

  csa_resolver #(.WIDTH(32), .CHUNK(5)) u_c5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_sum(in_sum), .in_cout(in_cout), .out_valid(vld[2]),
    .out_ready(out_ready), .out_result(res[2])
`ifdef CSA_RESOLVER_OVF_EN
    , .out_ovf(ovf[2])
`endif
  );

`ifndef CSA_RESOLVER_OVF_EN
  initial begin
    ovf[0] = 1'b0;
    ovf[1] = 1'b0;
    ovf[2] = 1'b0;
  end
`endif

  task automatic chk(input string name, input int k, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h",
               name, k, cyc, got, want);
    end
  endtask

  function automatic logic [33:0] model_sum(input logic [31:0] s,
                                            input logic [31:0] c);
    return 34'(s) + 34'(c) * 34'd2;
  endfunction

  // Compare at the falling edge, advance the model with the inputs that the
  // next rising edge will sample, then return 1 time unit after that edge.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic ev;
      ev = pend[k] && (cyc >= acc[k] + nb[k]);
      chk("in_ready", k, 64'(rdy[k]), 64'(!pend[k]));
      chk("out_valid", k, 64'(vld[k]), 64'(ev));
      if (ev) begin
        chk("out_result", k, 64'(res[k]), 64'(expv[k]));
`ifdef CSA_RESOLVER_OVF_EN
        chk("out_ovf", k, 64'(ovf[k]), 64'(expv[k] >= 34'h100000000));
`endif
      end
      if (rst) begin
        pend[k] = 1'b0;
      end else if (ev && out_ready) begin
        pend[k] = 1'b0;
        if (k == 0) done0++;
      end else if (!pend[k] && in_valid) begin
        pend[k] = 1'b1;
        expv[k] = model_sum(in_sum, in_cout);
        acc[k]  = cyc + 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (!(rdy[0] && rdy[1] && rdy[2]) && n < 20) begin
      step();
      n++;
    end
    chk("idle_wait", 0, 64'(rdy[0] && rdy[1] && rdy[2]), 64'd1);
    out_ready = 1'b0;
  endtask

  task automatic do_txn(input logic [31:0] s, input logic [31:0] c,
                        input logic [33:0] lit, input logic lit_ovf,
                        input int hold);
    int n;
    wait_idle();
    in_valid = 1'b1;
    in_sum   = s;
    in_cout  = c;
    step();
    in_valid = 1'b0;
    chk("accepted", 0, 64'(rdy[0]), 64'd0);
    n = 0;
    while (!vld[0] && n < 40) begin
      step();
      n++;
    end
    chk("latency", 0, 64'(n), 64'd5);
    chk("lit_result", 0, 64'(res[0]), 64'(lit));
`ifdef CSA_RESOLVER_OVF_EN
    chk("lit_ovf", 0, 64'(ovf[0]), 64'(lit_ovf));
`else
    chk("lit_ovf_absent", 0, 64'(ovf[0]), 64'd0);
`endif
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_result", 0, 64'(res[0]), 64'(lit));
      chk("hold_in_ready", 0, 64'(rdy[0]), 64'd0);
      chk("hold_valid", 0, 64'(vld[0]), 64'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ready_after_drain", 0, 64'(rdy[0]), 64'd1);
    chk("valid_after_drain", 0, 64'(vld[0]), 64'd0);
    $display("txn sum=0x%08h cout=0x%08h -> result=0x%09h latency=%0d hold=%0d",
             s, c, res[0], n, hold);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom & 32'hFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      pend[k] = 1'b0;
      expv[k] = '0;
      acc[k]  = 0;
    end
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_cout   = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_in_ready", 0, 64'(rdy[0]), 64'd1);
    chk("reset_out_valid", 0, 64'(vld[0]), 64'd0);
    chk("reset_out_result", 0, 64'(res[0]), 64'd0);
    chk("reset_out_ovf", 0, 64'(ovf[0]), 64'd0);

    do_txn(32'h0000_0005, 32'h0000_0001, 34'h7, 1'b0, 0);
    do_txn(32'hFFFF_FFFF, 32'h0000_0001, 34'h1_0000_0001, 1'b1, 0);
    do_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 34'h2_FFFF_FFFD, 1'b1, 0);
    do_txn(32'h0000_1234, 32'h0000_0010, 34'h1254, 1'b0, 10);

    // Reset during the third BUSY beat of the CHUNK=8 instance.
    wait_idle();
    in_valid = 1'b1;
    in_sum   = 32'hDEAD_BEEF;
    in_cout  = 32'h1234_5678;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_in_ready", 0, 64'(rdy[0]), 64'd1);
    chk("rst_out_valid", 0, 64'(vld[0]), 64'd0);
    chk("rst_out_result", 0, 64'(res[0]), 64'd0);
    do_txn(32'h0000_0010, 32'h0000_0008, 34'h20, 1'b0, 0);

    // Random traffic with stalls on both sides.
    for (int i = 0; i < 25000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sum    = rnd32();
      in_cout   = rnd32();
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    wait_idle();
    $display("random phase: %0d results drained from the CHUNK=8 instance", done0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
